// File: rtl/edge_event_capture.sv
// Multi-channel synchronised edge detector with sticky flags, saturating event counter and irq.
// Optional per-channel debounce filter is enabled by defining EDGE_DEBOUNCE_EN.
module edge_event_capture #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] flag_clr,
  input  logic [WIDTH-1:0] irq_en,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] event_flags,
  output logic [CNT_W-1:0] event_cnt,
  output logic             irq
);

  localparam int unsigned WarmW = $clog2(SYNC_STAGES + 2);
  localparam int unsigned SumW  = CNT_W + 6;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WarmW-1:0] warm_q, warm_d;
  logic             warm;
  logic [WIDTH-1:0] accept;
  logic [5:0]       pop;
  logic [SumW-1:0]  sum;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign warm     = (warm_q != '0);
  assign warm_d   = warm ? warm_q - WarmW'(1) : warm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0][DbW-1:0] db_q, db_d;

  // Counter holds the number of consecutive differing cycles already seen; the level moves on the
  // cycle after it reaches DEBOUNCE_CYCLES. Warm-up bypasses the filter.
  always_comb begin
    db_d   = '0;
    accept = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync_out[i] != level_q[i]) begin
        if (warm || db_q[i] == DbW'(DEBOUNCE_CYCLES)) begin
          accept[i] = 1'b1;
        end else begin
          db_d[i] = db_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q <= '0;
    end else begin
      db_q <= db_d;
    end
  end
`else
  assign accept = sync_out ^ level_q;
`endif

  always_comb begin
    level_d = level_q ^ accept;
    pulse_d = '0;
    if (!warm) begin
      pulse_d = accept & ((sync_out & rise_en) | (~sync_out & fall_en));
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + 6'(pulse_q[i]);
    end
  end

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    sum     = '0;
    if (!warm) begin
      // Set beats clear when both hit the same bit.
      flags_d = (flags_q & ~flag_clr) | pulse_q;
      sum     = (cnt_clr ? SumW'(0) : SumW'(cnt_q)) + SumW'(pop);
      cnt_d   = (sum > SumW'(CntMax)) ? CntMax : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
      pulse_q <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      warm_q  <= WarmW'(SYNC_STAGES + 1);
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
    end
  end

  assign level_out   = level_q;
  assign edge_pulse  = pulse_q;
  assign event_flags = flags_q;
  assign event_cnt   = cnt_q;
  assign irq         = |(flags_q & irq_en);

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed self-checking bench for edge_event_capture (WIDTH=8, SYNC_STAGES=2, CNT_W=4).
module tb_edge_event_capture;

`ifdef EDGE_DEBOUNCE_EN
  localparam int Db = 16;
`else
  localparam int Db = 0;
`endif
  // Edges after a pin change before the pulse edge.
  localparam int Lat = 2 + Db;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pin_in = '0, rise_en = '0, fall_en = '0, flag_clr = '0, irq_en = '0;
  logic       cnt_clr = 1'b0;
  logic [7:0] level_out, edge_pulse, event_flags;
  logic [3:0] event_cnt;
  logic       irq;
  int checks = 0;
  int failures = 0;

  edge_event_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .rise_en(rise_en), .fall_en(fall_en),
    .flag_clr(flag_clr), .irq_en(irq_en), .cnt_clr(cnt_clr), .level_out(level_out),
    .edge_pulse(edge_pulse), .event_flags(event_flags), .event_cnt(event_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] pins);
    pin_in = pins;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    irq_en = 8'hFF;
    rst_n = 1'b0;
    step();
    step();
    checks++; if (level_out !== 8'h00) begin failures++; $display("FAIL reset_level got=%h want=00", level_out); end
    checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL reset_pulse got=%h want=00", edge_pulse); end
    checks++; if (event_flags !== 8'h00) begin failures++; $display("FAIL reset_flags got=%h want=00", event_flags); end
    checks++; if (event_cnt !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%h want=0", event_cnt); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset_high();
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin_in = 8'hFF;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL warm_pulse cyc=%0d got=%h want=00", k, edge_pulse); end
    end
    checks++; if (level_out !== 8'hFF) begin failures++; $display("FAIL warm_level got=%h want=FF", level_out); end
    checks++; if (event_cnt !== 4'h0) begin failures++; $display("FAIL warm_cnt got=%h want=0", event_cnt); end
    rise_en = 8'h00;
    fall_en = 8'h00;
  endtask

  task automatic test_rise();
    do_reset(8'h00);
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    irq_en = 8'h08;
    pin_in = 8'h08;
    repeat (Lat) step();
    checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL rise_early got=%h want=00", edge_pulse); end
    step();
    checks++; if (edge_pulse !== 8'h08) begin failures++; $display("FAIL rise_pulse got=%h want=08", edge_pulse); end
    step();
    checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL rise_pulse_end got=%h want=00", edge_pulse); end
    checks++; if (event_flags !== 8'h08) begin failures++; $display("FAIL rise_flags got=%h want=08", event_flags); end
    checks++; if (event_cnt !== 4'h1) begin failures++; $display("FAIL rise_cnt got=%h want=1", event_cnt); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq got=%b want=1", irq); end
    checks++; if (level_out !== 8'h08) begin failures++; $display("FAIL rise_level got=%h want=08", level_out); end
    flag_clr = 8'h08;
    step();
    flag_clr = 8'h00;
    checks++; if (event_flags !== 8'h00) begin failures++; $display("FAIL clr_flags got=%h want=00", event_flags); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq got=%b want=0", irq); end
  endtask

  task automatic test_enables();
    rise_en = 8'h00;
    fall_en = 8'h00;
    pin_in = 8'h00;
    for (int k = 0; k < Lat + 2; k++) begin
      step();
      checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL dis_pulse cyc=%0d got=%h want=00", k, edge_pulse); end
    end
    checks++; if (level_out !== 8'h00) begin failures++; $display("FAIL dis_level got=%h want=00", level_out); end
    checks++; if (event_cnt !== 4'h1) begin failures++; $display("FAIL dis_cnt got=%h want=1", event_cnt); end
    fall_en = 8'hFF;
    pin_in = 8'h01;
    repeat (Lat + 1) step();
    checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL fall_only_rise got=%h want=00", edge_pulse); end
    checks++; if (level_out !== 8'h01) begin failures++; $display("FAIL fall_only_level got=%h want=01", level_out); end
    pin_in = 8'h00;
    repeat (Lat + 1) step();
    checks++; if (edge_pulse !== 8'h01) begin failures++; $display("FAIL fall_pulse got=%h want=01", edge_pulse); end
    step();
    checks++; if (event_cnt !== 4'h2) begin failures++; $display("FAIL fall_cnt got=%h want=2", event_cnt); end
  endtask

  task automatic test_flag_set_wins();
    flag_clr = 8'hFF;
    step();
    flag_clr = 8'h00;
    checks++; if (event_flags !== 8'h00) begin failures++; $display("FAIL wins_pre got=%h want=00", event_flags); end
    rise_en = 8'h01;
    fall_en = 8'h00;
    pin_in = 8'h01;
    repeat (Lat + 1) step();
    checks++; if (edge_pulse !== 8'h01) begin failures++; $display("FAIL wins_pulse got=%h want=01", edge_pulse); end
    flag_clr = 8'h01;
    step();
    checks++; if (event_flags !== 8'h01) begin failures++; $display("FAIL wins_set got=%h want=01", event_flags); end
    step();
    flag_clr = 8'h00;
    checks++; if (event_flags !== 8'h00) begin failures++; $display("FAIL wins_clr got=%h want=00", event_flags); end
  endtask

  task automatic test_saturate();
    logic [7:0] p;
    int exp_cnt;
    do_reset(8'h00);
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    p = 8'h00;
    exp_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      p = p ^ 8'h0F;
      pin_in = p;
      repeat (Lat + 1) step();
      checks++; if (edge_pulse !== 8'h0F) begin failures++; $display("FAIL sat_pulse t=%0d got=%h want=0F", t, edge_pulse); end
      step();
      exp_cnt = (exp_cnt + 4 > 15) ? 15 : exp_cnt + 4;
      checks++; if (event_cnt !== 4'(exp_cnt)) begin failures++; $display("FAIL sat_cnt t=%0d got=%0d want=%0d", t, event_cnt, exp_cnt); end
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (event_cnt !== 4'h0) begin failures++; $display("FAIL cnt_clr got=%h want=0", event_cnt); end
    p = p ^ 8'h0F;
    pin_in = p;
    repeat (Lat + 1) step();
    checks++; if (edge_pulse !== 8'h0F) begin failures++; $display("FAIL clr_pulse got=%h want=0F", edge_pulse); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (event_cnt !== 4'h4) begin failures++; $display("FAIL clr_with_pulse got=%h want=4", event_cnt); end
  endtask

  task automatic test_mid_pulse_reset();
    pin_in = pin_in ^ 8'h20;
    repeat (Lat + 1) step();
    checks++; if (edge_pulse !== 8'h20) begin failures++; $display("FAIL mid_pulse got=%h want=20", edge_pulse); end
    rst_n = 1'b0;
    step();
    checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL mid_rst_pulse got=%h want=00", edge_pulse); end
    checks++; if (level_out !== 8'h00) begin failures++; $display("FAIL mid_rst_level got=%h want=00", level_out); end
    checks++; if (event_flags !== 8'h00) begin failures++; $display("FAIL mid_rst_flags got=%h want=00", event_flags); end
    checks++; if (event_cnt !== 4'h0) begin failures++; $display("FAIL mid_rst_cnt got=%h want=0", event_cnt); end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL mid_warm_pulse cyc=%0d got=%h want=00", k, edge_pulse); end
    end
    checks++; if (level_out !== pin_in) begin failures++; $display("FAIL mid_warm_level got=%h want=%h", level_out, pin_in); end
    checks++; if (event_cnt !== 4'h0) begin failures++; $display("FAIL mid_warm_cnt got=%h want=0", event_cnt); end
  endtask

`ifdef EDGE_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset(8'h00);
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin_in = 8'h04;
    repeat (10) step();
    pin_in = 8'h00;
    for (int k = 0; k < 25; k++) begin
      step();
      checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL glitch_pulse cyc=%0d got=%h want=00", k, edge_pulse); end
    end
    checks++; if (level_out !== 8'h00) begin failures++; $display("FAIL glitch_level got=%h want=00", level_out); end
    pin_in = 8'h04;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 18) begin
        checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL db_early got=%h want=00", edge_pulse); end
      end
      if (k == 19) begin
        checks++; if (edge_pulse !== 8'h04) begin failures++; $display("FAIL db_pulse got=%h want=04", edge_pulse); end
      end
      if (k == 20) begin
        checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL db_single got=%h want=00", edge_pulse); end
      end
    end
    pin_in = 8'h06;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    checks++; if ({level_out, edge_pulse, event_flags} !== 24'h0) begin failures++; $display("FAIL db_rst got=%h want=0", {level_out, edge_pulse, event_flags}); end
    checks++; if (event_cnt !== 4'h0) begin failures++; $display("FAIL db_rst_cnt got=%h want=0", event_cnt); end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (edge_pulse !== 8'h00) begin failures++; $display("FAIL db_warm_pulse cyc=%0d got=%h want=00", k, edge_pulse); end
    end
    checks++; if (level_out !== 8'h06) begin failures++; $display("FAIL db_warm_level got=%h want=06", level_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_high();
    test_rise();
    test_enables();
    test_flag_set_wins();
    test_saturate();
    test_mid_pulse_reset();
`ifdef EDGE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
